// File: rtl/nn_result_serializer.sv
// Snapshots the output neuron's loss and final result, then streams them as a
// byte frame: header, payload bytes LSB first, XOR checksum.
module nn_result_serializer #(
  parameter int          LOSS_W  = 46,
  parameter int          FINAL_W = 23,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               cap_i,
  input  logic [LOSS_W-1:0]  loss_i,
  input  logic [FINAL_W-1:0] final_i,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  input  logic               byte_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o
);

  localparam int PAY_W  = LOSS_W + FINAL_W;
  localparam int NBYTES = (PAY_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CSUM} state_t;

  state_t             state_r;
  logic [PAD_W-1:0]   payload_r;
  logic [IDX_W-1:0]   idx_r;
  logic [7:0]         csum_r;
  logic [7:0]         byte_r;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;
  logic               overrun_r;

  logic               xfer_s;
  logic               cap_req_s;

  function automatic logic [PAD_W-1:0] pack_payload(input logic [LOSS_W-1:0]  loss,
                                                    input logic [FINAL_W-1:0] fin);
    logic [PAD_W-1:0] p;
    p            = {PAD_W{1'b0}};
    p[PAY_W-1:0] = {fin, loss};
    return p;
  endfunction

  function automatic logic [7:0] payload_byte(input logic [PAD_W-1:0] p,
                                              input logic [IDX_W-1:0] k);
    return p[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction

  assign xfer_s    = valid_r && byte_ready_i;
  assign cap_req_s = en_i && cap_i;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      payload_r <= {PAD_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      csum_r    <= 8'h00;
      byte_r    <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cap_req_s) begin
            payload_r <= pack_payload(loss_i, final_i);
            csum_r    <= HDR;
            idx_r     <= {IDX_W{1'b0}};
            byte_r    <= HDR;
            valid_r   <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ST_HDR;
          end else begin
            byte_r  <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_HDR: begin
          if (cap_req_s) overrun_r <= 1'b1;
          if (xfer_s) begin
            byte_r  <= payload_byte(payload_r, {IDX_W{1'b0}});
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cap_req_s) overrun_r <= 1'b1;
          if (xfer_s) begin
            csum_r <= csum_update(csum_r, byte_r);
            if (idx_r == LAST_IDX) begin
              byte_r  <= csum_update(csum_r, byte_r);
              state_r <= ST_CSUM;
            end else begin
              idx_r  <= idx_r + IDX_W'(1);
              byte_r <= payload_byte(payload_r, idx_r + IDX_W'(1));
            end
          end
        end
        ST_CSUM: begin
          if (xfer_s) begin
            done_r <= 1'b1;
            // A capture coinciding with the checksum transfer starts the next frame directly.
            if (cap_req_s) begin
              payload_r <= pack_payload(loss_i, final_i);
              csum_r    <= HDR;
              idx_r     <= {IDX_W{1'b0}};
              byte_r    <= HDR;
              state_r   <= ST_HDR;
            end else begin
              byte_r  <= 8'h00;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else if (cap_req_s) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          byte_r  <= 8'h00;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_o       = byte_r;
  assign byte_valid_o = valid_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_nn_result_serializer.sv
// Directed bench for nn_result_serializer with hand-computed frames.
module tb_nn_result_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        cap_i;
  logic [45:0] loss_i;
  logic [22:0] final_i;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] f_zero [11];
  logic [7:0] f_max  [11];
  logic [7:0] f_one  [11];

  nn_result_serializer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .cap_i        (cap_i),
    .loss_i       (loss_i),
    .final_i      (final_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one frame already showing its header; stops with the checksum on byte_o.
  task automatic run_frame(input logic [7:0] e [11], input int stall_at, input int cap_at);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("byte%0d", i), {24'h0, byte_o}, {24'h0, e[i]});
      chk($sformatf("valid%0d", i), {31'h0, byte_valid_o}, 32'h1);
      chk($sformatf("busy%0d", i), {31'h0, busy_o}, 32'h1);
      if (i == stall_at) begin
        byte_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_byte", {24'h0, byte_o}, {24'h0, e[i]});
          chk("stall_valid", {31'h0, byte_valid_o}, 32'h1);
        end
        byte_ready_i = 1'b1;
      end
      if (i < 10) begin
        if (i == cap_at) begin
          en_i  = 1'b1;
          cap_i = 1'b1;
        end
        step();
        cap_i = 1'b0;
      end
    end
  endtask

  task automatic check_idle_after(input string tag);
    chk({tag, "_done"}, {31'h0, done_o}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_valid"}, {31'h0, byte_valid_o}, 32'h0);
    chk({tag, "_byte"}, {24'h0, byte_o}, 32'h0);
  endtask

  initial begin
    f_zero = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
    f_max  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hFF, 8'hFF, 8'h1F, 8'h7B};
    f_one  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'hE5};

    rst_i = 1'b0; en_i = 1'b0; cap_i = 1'b0; byte_ready_i = 1'b1;
    loss_i = 46'h0; final_i = 23'h0;
    step(); step();
    chk("rst_byte", {24'h0, byte_o}, 32'h0);
    chk("rst_valid", {31'h0, byte_valid_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_ovr", {31'h0, overrun_o}, 32'h0);
    rst_i = 1'b1;
    step();

    // Frame of zeros, sink always ready.
    en_i = 1'b1; cap_i = 1'b1;
    step();
    cap_i = 1'b0;
    run_frame(f_zero, -1, -1);
    step();
    check_idle_after("f1");
    step();
    chk("f1_done_once", {31'h0, done_o}, 32'h0);

    // Capture with enable low is ignored.
    en_i = 1'b0; cap_i = 1'b1;
    step(); step();
    chk("en0_busy", {31'h0, busy_o}, 32'h0);
    chk("en0_valid", {31'h0, byte_valid_o}, 32'h0);
    chk("en0_ovr", {31'h0, overrun_o}, 32'h0);
    cap_i = 1'b0;

    // Extreme values with a stall on C0; inputs scrambled after capture; back-to-back next.
    loss_i = 46'h1; final_i = 23'h7FFFFF; en_i = 1'b1; cap_i = 1'b1;
    step();
    cap_i = 1'b0;
    loss_i = 46'h2A5A_1234_5678; final_i = 23'h12345;
    run_frame(f_max, 6, -1);
    loss_i = 46'h0; final_i = 23'h1; cap_i = 1'b1;
    step();
    cap_i = 1'b0;
    chk("b2b_done", {31'h0, done_o}, 32'h1);
    chk("b2b_hdr", {24'h0, byte_o}, 32'hA5);
    chk("b2b_valid", {31'h0, byte_valid_o}, 32'h1);
    chk("b2b_ovr", {31'h0, overrun_o}, 32'h0);

    // Back-to-back frame; a capture mid-frame must be dropped and flagged.
    run_frame(f_one, -1, 4);
    chk("ovr_set", {31'h0, overrun_o}, 32'h1);
    step();
    check_idle_after("f3");
    chk("ovr_sticky", {31'h0, overrun_o}, 32'h1);

    // Reset during payload aborts at once.
    loss_i = 46'h0; final_i = 23'h0; cap_i = 1'b1;
    step();
    cap_i = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    rst_i = 1'b0;
    #1;
    chk("arst_byte", {24'h0, byte_o}, 32'h0);
    chk("arst_valid", {31'h0, byte_valid_o}, 32'h0);
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_ovr", {31'h0, overrun_o}, 32'h0);
    step();
    rst_i = 1'b1;
    step();

    loss_i = 46'h1; final_i = 23'h7FFFFF; cap_i = 1'b1;
    step();
    cap_i = 1'b0;
    run_frame(f_max, -1, -1);
    step();
    check_idle_after("f4");
    chk("f4_ovr", {31'h0, overrun_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
